// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll pipeline: die codes, scheduler state
// encoding and default datapath widths.
package dice_pkg;

  localparam int unsigned DIE_W_DEF  = 4;
  localparam int unsigned ROLL_W_DEF = 5;

  localparam int unsigned D4  = 0;
  localparam int unsigned D6  = 1;
  localparam int unsigned D8  = 2;
  localparam int unsigned D10 = 3;
  localparam int unsigned D12 = 4;
  localparam int unsigned D20 = 5;
  localparam int unsigned DIE_MAX = D20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RUN,
    S_RESP
  } sched_state_t;

  // Codes above DIE_MAX have no postProcess table and are rejected.
  function automatic logic die_code_valid(input logic [31:0] code);
    return code <= DIE_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request after ptr,
// wrapping modulo N_REQ. The pointer register belongs to the caller.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk ptr+1 .. ptr+N_REQ and keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] k;
    k     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/roll_scheduler.sv
// Shares the single random-roll pipeline between N_REQ requesters with
// round-robin arbitration, one roll in flight at a time.
// Optional feature macro: ROLL_SCHED_TIMEOUT_EN (abort RUN after TIMEOUT_CYC cycles).
module roll_scheduler
  import dice_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DIE_W       = DIE_W_DEF,
  parameter int unsigned ROLL_W      = ROLL_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DIE_W-1:0] i_die_sel,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done,
  output logic [ROLL_W-1:0]      o_roll,
  output logic                   o_err,
  output logic [DIE_W-1:0]       o_die_select,
  output logic                   o_rng_start,
  input  logic                   i_roll_valid,
  input  logic [ROLL_W-1:0]      i_roll_result
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2) begin : g_chk_nreq
    $error("roll_scheduler: N_REQ must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_chk_timeout
    $error("roll_scheduler: TIMEOUT_CYC must be at least 1");
  end

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [DIE_W-1:0] die_q;
  logic             valid_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [DIE_W-1:0] die_pick;
  logic             roll_edge;

`ifdef ROLL_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] run_cnt;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Die code of the requester the arbiter would pick this cycle.
  always_comb begin
    die_pick = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (arb_grant[k]) die_pick = i_die_sel[k*DIE_W +: DIE_W];
    end
  end

  // A valid level left over from the previous roll is not a new result.
  assign roll_edge = i_roll_valid & ~valid_q;

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      ptr          <= IDX_W'(N_REQ - 1);
      die_q        <= '0;
      valid_q      <= 1'b0;
      o_grant      <= '0;
      o_done       <= '0;
      o_roll       <= '0;
      o_err        <= 1'b0;
      o_die_select <= '0;
      o_rng_start  <= 1'b0;
`ifdef ROLL_SCHED_TIMEOUT_EN
      run_cnt      <= '0;
`endif
    end else begin
      valid_q <= i_roll_valid;
      o_done  <= '0;
      o_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            state   <= S_GRANT;
            o_grant <= arb_grant;
            ptr     <= arb_idx;
            die_q   <= die_pick;
          end
        end
        S_GRANT: begin
          if (die_code_valid(32'(die_q))) begin
            state        <= S_RUN;
            o_rng_start  <= 1'b1;
            o_die_select <= die_q;
`ifdef ROLL_SCHED_TIMEOUT_EN
            run_cnt      <= '0;
`endif
          end else begin
            state  <= S_RESP;
            o_done <= o_grant;
            o_err  <= 1'b1;
            o_roll <= '0;
          end
        end
        S_RUN: begin
          if (roll_edge) begin
            state       <= S_RESP;
            o_done      <= o_grant;
            o_roll      <= i_roll_result;
            o_rng_start <= 1'b0;
          end
`ifdef ROLL_SCHED_TIMEOUT_EN
          else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state       <= S_RESP;
            o_done      <= o_grant;
            o_err       <= 1'b1;
            o_roll      <= '0;
            o_rng_start <= 1'b0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          state   <= S_IDLE;
          o_grant <= '0;
        end
        default: begin
          state   <= S_IDLE;
          o_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roll_scheduler.sv
// Self-checking bench for roll_scheduler: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_roll_scheduler;
  import dice_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int RW = 5;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] die_sel;
  logic            valid;
  logic [RW-1:0]   result;
  logic [N-1:0]    grant, done;
  logic [RW-1:0]   roll;
  logic            err;
  logic [DW-1:0]   dsel;
  logic            start;

  always #5 clk = ~clk;

  roll_scheduler #(
    .N_REQ       (N),
    .DIE_W       (DW),
    .ROLL_W      (RW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req         (req),
    .i_die_sel     (die_sel),
    .o_grant       (grant),
    .o_done        (done),
    .o_roll        (roll),
    .o_err         (err),
    .o_die_select  (dsel),
    .o_rng_start   (start),
    .i_roll_valid  (valid),
    .i_roll_result (result)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one roll transaction at a time) -------
  int           m_owner;     // -1 when nobody owns the pipeline
  int           m_ptr;       // last winner
  int           m_run;       // -1 in the grant cycle, else RUN cycles elapsed
  bit           m_resp;      // done is being presented this cycle
  bit           m_prev_valid;
  logic [DW-1:0] m_die;
  logic [N-1:0]  e_grant, e_done;
  logic [RW-1:0] e_roll;
  logic          e_err, e_start;
  logic [DW-1:0] e_dsel;

  function automatic void model_reset();
    m_owner = -1; m_ptr = N - 1; m_run = -1; m_resp = 0; m_prev_valid = 0;
    m_die = '0;
    e_grant = '0; e_done = '0; e_roll = '0; e_err = 0; e_start = 0; e_dsel = '0;
  endfunction

  function automatic void finish_roll(input logic [RW-1:0] r, input logic is_err);
    m_resp  = 1;
    e_done  = e_grant;
    e_roll  = r;
    e_err   = is_err;
    e_start = 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  function automatic void model_clock();
    bit edge_seen;
    edge_seen    = valid && !m_prev_valid;
    m_prev_valid = valid;
    e_done = '0;
    e_err  = 0;
    if (m_resp) begin
      m_resp  = 0;
      m_owner = -1;
      e_grant = '0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (req[k]) begin
          m_owner = k;
          break;
        end
      end
      if (m_owner >= 0) begin
        m_ptr = m_owner;
        m_die = die_sel[m_owner*DW +: DW];
        m_run = -1;
        e_grant = '0;
        e_grant[m_owner] = 1'b1;
      end
    end else if (m_run < 0) begin
      if (m_die > DIE_MAX) finish_roll('0, 1'b1);
      else begin
        m_run   = 0;
        e_start = 1;
        e_dsel  = m_die;
      end
    end else begin
      if (edge_seen) finish_roll(result, 1'b0);
`ifdef ROLL_SCHED_TIMEOUT_EN
      else if (m_run + 1 >= TO) finish_roll('0, 1'b1);
`endif
      else m_run++;
    end
  endfunction

  task automatic compare_all();
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("done",  32'(done),  32'(e_done));
    check_eq("roll",  32'(roll),  32'(e_roll));
    check_eq("err",   32'(err),   32'(e_err));
    check_eq("start", 32'(start), 32'(e_start));
    check_eq("dsel",  32'(dsel),  32'(e_dsel));
  endtask

  // Inputs change only at negedge; outputs are compared at negedge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  // One-cycle asynchronous reset pulse starting just after a negedge.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_done",  32'(done),  0);
    check_eq("rst_roll",  32'(roll),  0);
    check_eq("rst_err",   32'(err),   0);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_dsel",  32'(dsel),  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] pick_die();
    if ($urandom_range(0, 7) == 0) return DW'($urandom_range(6, 15));
    return DW'($urandom_range(0, 5));
  endfunction

  // Random requesters plus a loose emulation of the SIPO/postProcess pipeline.
  task automatic drive_random();
    if (e_start) begin
      if (!valid) begin
        result = RW'($urandom);
        if ($urandom_range(0, 5) == 0) valid = 1'b1;
      end else if ($urandom_range(0, 7) == 0) valid = 1'b0;
    end else begin
      if (valid && $urandom_range(0, 2) == 0) valid = 1'b0;
      else if (!valid && $urandom_range(0, 24) == 0) valid = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (e_done[k]) begin
        if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
      end else if (!req[k]) begin
        if ($urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          die_sel[k*DW +: DW] = pick_die();
        end
      end else if (e_grant[k]) begin
        if ($urandom_range(0, 29) == 0) req[k] = 1'b0;
        if ($urandom_range(0, 4) == 0) die_sel[k*DW +: DW] = DW'($urandom);
      end
    end
    if ($urandom_range(0, 399) == 0) pulse_reset();
  endtask

  initial begin
    req = '0; die_sel = '0; valid = 1'b0; result = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // 1: requester 0, d6, result arrives 20 cycles into RUN
    req = 4'b0001;
    die_sel[3:0] = DW'(D6);
    step();
    check_eq("t1_grant", 32'(grant), 1);
    step();
    check_eq("t1_start", 32'(start), 1);
    check_eq("t1_dsel",  32'(dsel),  D6);
    repeat (19) step();
    valid = 1'b1; result = 5'd4;
    step();
    check_eq("t1_done", 32'(done), 1);
    check_eq("t1_roll", 32'(roll), 4);
    check_eq("t1_err",  32'(err),  0);
    req = '0;
    step();
    check_eq("t1_idle", 32'(grant), 0);
    valid = 1'b0;
    step();

    // 2: requesters 1 and 2 held together alternate
    pulse_reset();
    req = 4'b0110;
    die_sel[7:4]  = DW'(D8);
    die_sel[11:8] = DW'(D20);
    begin
      logic [N-1:0] exp_done;
      int n_done;
      exp_done = 4'b0010;
      n_done   = 0;
      for (int c = 0; c < 60; c++) begin
        if (e_start) begin
          valid  = 1'b1;
          result = RW'($urandom);
        end else valid = 1'b0;
        step();
        if (done != 0) begin
          check_eq("t2_order", 32'(done), 32'(exp_done));
          exp_done = (exp_done == 4'b0010) ? 4'b0100 : 4'b0010;
          n_done++;
        end
      end
      check_eq("t2_count", 32'(n_done >= 10), 1);
    end
    req = '0; valid = 1'b0;
    step();

    // 3: invalid die code on requester 3
    pulse_reset();
    req = 4'b1000;
    die_sel[15:12] = 4'd9;
    step();
    check_eq("t3_start1", 32'(start), 0);
    step();
    check_eq("t3_done",   32'(done),  4'b1000);
    check_eq("t3_err",    32'(err),   1);
    check_eq("t3_roll",   32'(roll),  0);
    check_eq("t3_start2", 32'(start), 0);
    req = '0;
    step();

    // 4: valid left high from the previous roll; no new edge
    pulse_reset();
    req = 4'b0001;
    die_sel[3:0] = DW'(D4);
    step(); step();
    valid = 1'b1; result = 5'd7;
    step();
    check_eq("t4_first", 32'(done), 1);
`ifdef ROLL_SCHED_TIMEOUT_EN
    begin
      int runc;
      bit seen;
      runc = 0; seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        step();
        if (start) runc++;
        if (done != 0) begin
          seen = 1;
          check_eq("t4_done", 32'(done), 1);
          check_eq("t4_err",  32'(err),  1);
          check_eq("t4_roll", 32'(roll), 0);
          check_eq("t4_runc", 32'(runc), TO);
          req = '0;
        end
      end
      check_eq("t4_seen", 32'(seen), 1);
    end
`else
    repeat (40) step();
    check_eq("t4_stuck", 32'(start), 1);
    check_eq("t4_grant", 32'(grant), 1);
    valid = 1'b0;
    step();
    valid = 1'b1; result = 5'd3;
    step();
    check_eq("t4_late", 32'(roll), 3);
    req = '0;
`endif
    step();
    valid = 1'b0;
    step();

    // 5: reset in the middle of RUN, then requester 0 wins first
    pulse_reset();
    req = 4'b0100;
    die_sel[11:8] = DW'(D10);
    repeat (4) step();
    check_eq("t5_run", 32'(start), 1);
    pulse_reset();
    req = 4'b1111;
    die_sel = {4'(D12), 4'(D10), 4'(D8), 4'(D6)};
    step();
    check_eq("t5_first", 32'(grant), 1);
    req = '0;
    step();

    // 6: request dropped mid-roll still completes
    pulse_reset();
    req = 4'b0001;
    die_sel[3:0] = DW'(D12);
    step(); step(); step();
    req = '0;
    repeat (3) step();
    valid = 1'b1; result = 5'd17;
    step();
    check_eq("t6_done", 32'(done), 1);
    check_eq("t6_roll", 32'(roll), 17);
    step();
    check_eq("t6_idle", 32'(grant), 0);
    valid = 1'b0;

    // randomized traffic
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
